// File: rtl/muldiv_seq.sv
// Purpose : multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, plus MTHI/MTLO/MFHI/MFLO access.
// Latency : mul/div result in HI/LO after WIDTH+1 edges (33 at WIDTH=32); MT* one edge; MF* combinational.
// Backpressure: FREEZE holds the front of the pipeline while busy; start is ignored unless IDLE.
// Optional: define MULDIV_SIGNED_EN to give op 0/2 signed semantics (otherwise they run unsigned).
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    input  logic             FLUSH,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] mf_data,
    output logic             FREEZE,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    // acc_hi: product upper half / partial remainder; acc_lo: multiplier / dividend-quotient
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    // multiplicand for multiply, divisor for divide
    logic [WIDTH-1:0] operand;
    logic             is_div;
    logic             by_zero;
`ifdef MULDIV_SIGNED_EN
    logic             neg_q;
    logic             neg_r;
`endif

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign FREEZE  = (state != IDLE);
    assign mf_data = (op == 3'd6) ? HI : LO;

    // Operand magnitudes captured at accept; only signed ops take absolute values
    always_comb begin
        abs_a = Operand_A;
        abs_b = Operand_B;
`ifdef MULDIV_SIGNED_EN
        if (op == 3'd0 || op == 3'd2) begin
            if (Operand_A[WIDTH-1]) abs_a = -Operand_A;
            if (Operand_B[WIDTH-1]) abs_b = -Operand_B;
        end
`endif
    end

    // One iteration of shift-add multiply and restoring divide, selected later by is_div
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
    end

    // Sign correction and result selection written to HI/LO on the FIX edge
    always_comb begin
        prod = {acc_hi, acc_lo};
        quo  = acc_lo;
        rem  = acc_hi;
`ifdef MULDIV_SIGNED_EN
        if (neg_q) begin
            prod = -{acc_hi, acc_lo};
            quo  = -acc_lo;
        end
        if (neg_r) rem = -acc_hi;
`endif
        if (is_div) begin
            if (by_zero) begin
                // remainder register has shifted the whole latched dividend back in
                fix_hi = acc_hi;
                fix_lo = {WIDTH{1'b1}};
            end else begin
                fix_hi = rem;
                fix_lo = quo;
            end
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    // Sequencer FSM with HI/LO ownership and registered div_zero pulse
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            by_zero  <= 1'b0;
            HI       <= '0;
            LO       <= '0;
            div_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            count   <= '0;
                            acc_hi  <= '0;
                            is_div  <= op[1];
                            by_zero <= (Operand_B == '0);
                            if (op[1]) begin
                                acc_lo  <= abs_a;
                                operand <= abs_b;
                            end else begin
                                acc_lo  <= abs_b;
                                operand <= abs_a;
                            end
`ifdef MULDIV_SIGNED_EN
                            if (op == 3'd0 || op == 3'd2) begin
                                neg_q <= Operand_A[WIDTH-1] ^ Operand_B[WIDTH-1];
                                neg_r <= Operand_A[WIDTH-1];
                            end else begin
                                neg_q <= 1'b0;
                                neg_r <= 1'b0;
                            end
`endif
                            state <= RUN;
                        end else if (op == 3'd4) begin
                            HI <= Operand_A;
                        end else if (op == 3'd5) begin
                            LO <= Operand_A;
                        end
                    end
                end
                RUN: begin
                    if (FLUSH) begin
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            if (!div_diff[WIDTH]) begin
                                acc_hi <= div_diff[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                            end else begin
                                acc_hi <= div_shift[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
                        count <= count + CW'(1);
                        if (count == LAST) state <= FIX;
                    end
                end
                FIX: begin
                    // a flush arriving with the write abandons the result entirely
                    if (!FLUSH) begin
                        HI       <= fix_hi;
                        LO       <= fix_lo;
                        div_zero <= is_div && by_zero;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    logic        CLK;
    logic        RESET;
    logic        start;
    logic [2:0]  op;
    logic [31:0] Operand_A;
    logic [31:0] Operand_B;
    logic        FLUSH;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] mf_data;
    logic        FREEZE;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .op        (op),
        .Operand_A (Operand_A),
        .Operand_B (Operand_B),
        .FLUSH     (FLUSH),
        .HI        (HI),
        .LO        (LO),
        .mf_data   (mf_data),
        .FREEZE    (FREEZE),
        .div_zero  (div_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        logic        dz;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request from a negedge and follow FREEZE until it drops (bounded)
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic dz_end, output int dz_early);
        @(negedge CLK);
        start = 1'b1; op = o; Operand_A = a; Operand_B = b;
        @(negedge CLK);
        start = 1'b0;
        cyc = 0;
        dz_early = 0;
        while (FREEZE && cyc < 100) begin
            cyc++;
            if (div_zero) dz_early++;
            @(negedge CLK);
        end
        dz_end = div_zero;
    endtask

    initial begin
        int   cyc;
        int   dz_early;
        logic dz_end;

        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b0};
`ifdef MULDIV_SIGNED_EN
        vecs[1]  = '{3'd0, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0};
        vecs[2]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33, 1'b0};
        vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0};
        vecs[4]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b0};
        vecs[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b0};
`else
        vecs[1]  = '{3'd0, 32'hFFFFFFF9, 32'h00000003, 32'h00000002, 32'hFFFFFFEB, 33, 1'b0};
        vecs[2]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b0};
        vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 33, 1'b0};
        vecs[4]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000007, 32'h00000000, 33, 1'b0};
        vecs[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33, 1'b0};
`endif
        vecs[6]  = '{3'd3, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 33, 1'b1};
        vecs[7]  = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 33, 1'b0};
        vecs[8]  = '{3'd3, 32'h00000007, 32'h00000064, 32'h00000007, 32'h00000000, 33, 1'b0};
        vecs[9]  = '{3'd1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 33, 1'b0};
        vecs[10] = '{3'd4, 32'h00001234, 32'h00000000, 32'h00001234, 32'h23456780, 0,  1'b0};
        vecs[11] = '{3'd5, 32'h0000CAFE, 32'h00000000, 32'h00001234, 32'h0000CAFE, 0,  1'b0};

        RESET = 1'b0; start = 1'b0; op = 3'd0; Operand_A = '0; Operand_B = '0; FLUSH = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset_hi", HI, 32'h0);
        chk("reset_lo", LO, 32'h0);
        chk("reset_freeze", {31'b0, FREEZE}, 32'h0);
        chk("reset_div_zero", {31'b0, div_zero}, 32'h0);
        RESET = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, dz_end, dz_early);
            chk($sformatf("vec%0d_freeze_cycles", i), cyc, vecs[i].cyc);
            chk($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
            chk($sformatf("vec%0d_div_zero", i), {31'b0, dz_end}, {31'b0, vecs[i].dz});
            chk($sformatf("vec%0d_div_zero_early", i), dz_early, 0);
            @(negedge CLK);
            chk($sformatf("vec%0d_div_zero_cleared", i), {31'b0, div_zero}, 32'h0);
        end

        // MFHI/MFLO are combinational and never freeze
        start = 1'b1; op = 3'd6;
        #1 chk("mfhi_comb", mf_data, 32'h00001234);
        op = 3'd7;
        #1 chk("mflo_comb", mf_data, 32'h0000CAFE);
        @(negedge CLK);
        start = 1'b0;
        chk("mf_no_freeze", {31'b0, FREEZE}, 32'h0);
        chk("mf_hi_kept", HI, 32'h00001234);

        // DIVU flushed at cycle 10, with an ignored MTHI presented while busy
        @(negedge CLK);
        start = 1'b1; op = 3'd3; Operand_A = 32'd100; Operand_B = 32'd7;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (i == 5) begin
                start = 1'b1; op = 3'd4; Operand_A = 32'hDEAD;
            end else begin
                start = 1'b0;
            end
            @(negedge CLK);
        end
        start = 1'b0;
        chk("flush_busy_before", {31'b0, FREEZE}, 32'h1);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        chk("flush_freeze_low", {31'b0, FREEZE}, 32'h0);
        chk("flush_hi_kept", HI, 32'h00001234);
        chk("flush_lo_kept", LO, 32'h0000CAFE);
        chk("flush_no_div_zero", {31'b0, div_zero}, 32'h0);
        start = 1'b1; op = 3'd6;
        #1 chk("flush_mfhi", mf_data, 32'h00001234);
        @(negedge CLK);
        start = 1'b0;

        // FLUSH coinciding with the FIX edge of a divide by zero
        @(negedge CLK);
        start = 1'b1; op = 3'd3; Operand_A = 32'd5; Operand_B = 32'd0;
        @(negedge CLK);
        start = 1'b0;
        repeat (32) @(negedge CLK);
        chk("fixflush_in_fix", {31'b0, FREEZE}, 32'h1);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        chk("fixflush_freeze_low", {31'b0, FREEZE}, 32'h0);
        chk("fixflush_hi_kept", HI, 32'h00001234);
        chk("fixflush_lo_kept", LO, 32'h0000CAFE);
        chk("fixflush_no_div_zero", {31'b0, div_zero}, 32'h0);

        // Reset asserted mid-RUN of MULTU
        @(negedge CLK);
        start = 1'b1; op = 3'd1; Operand_A = 32'h0000FFFF; Operand_B = 32'h00010001;
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("midreset_hi", HI, 32'h0);
        chk("midreset_lo", LO, 32'h0);
        chk("midreset_freeze", {31'b0, FREEZE}, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("midreset_idle_after", {31'b0, FREEZE}, 32'h0);

        run_op(3'd1, 32'd3, 32'd5, cyc, dz_end, dz_early);
        chk("post_reset_cycles", cyc, 33);
        chk("post_reset_hi", HI, 32'h0);
        chk("post_reset_lo", LO, 32'h0000000F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle multiply/divide sequencer owning the HI/LO register pair for the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests from decode and runs a radix-2 shift-add multiply or restoring divide over WIDTH iterations. While busy it drives FREEZE, which holds the front of the pipeline. It sits beside the ALU and replaces the ALU's combinational HI/LO outputs.

## Interface
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- start  in  1  request valid this cycle.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6=MFHI, 7=MFLO.
- Operand_A  in  WIDTH  multiplicand/dividend; MTHI/MTLO source.
- Operand_B  in  WIDTH  multiplier/divisor.
- FLUSH  in  1  abort an in-flight operation.
- HI  out  WIDTH  HI register; reset 0.
- LO  out  WIDTH  LO register; reset 0.
- mf_data  out  WIDTH  combinational: HI when op=6, LO otherwise.
- FREEZE  out  1  pipeline hold; reset 0.
- div_zero  out  1  one-cycle pulse, divisor was zero; reset 0.

## Operation
- States: IDLE, RUN, FIX. Reset forces IDLE, count=0, HI=LO=0, FREEZE=0, div_zero=0 and clears the internal accumulator and operand registers.
- IDLE with start and op 0-3: latch |A| and |B| for signed ops, or the raw operands for unsigned ops. Latch the result sign (A[31]^B[31] for the product and quotient, A[31] for the remainder). Clear count. Go to RUN.
- IDLE with start and op=4/5: write Operand_A to HI/LO at that edge. Stay IDLE.
- IDLE with start and op=6/7: no state change. mf_data is valid the same cycle.
- RUN: one iteration per cycle, count increments. Multiply: 64-bit shift-add. Divide: restoring shift-subtract, 1 quotient bit per cycle. After the count=WIDTH-1 edge, go to FIX.
- FIX: apply two's-complement sign correction to the product, or to the quotient and remainder separately. Write HI (product upper / remainder) and LO (product lower / quotient). Return to IDLE.
- Divide by zero: LO=all ones, HI=Operand_A as latched. No sign correction. div_zero pulses on the FIX edge.
- Signed 0x80000000 / -1: LO=0x80000000, HI=0. This falls out of the magnitude algorithm with no special case.
- FREEZE = (state != IDLE), combinational from state.
- start while not IDLE is ignored. The pipeline is frozen, so decode re-presents the request.
- FLUSH in RUN or FIX: return to IDLE next edge, HI/LO unchanged, no div_zero. FLUSH in IDLE has no effect. FLUSH wins over the FIX write when both occur on the same edge.
- RESET asserted mid-operation: immediate return to reset values; the operation is lost.

## Timing
- Accept on edge E0. RUN covers edges E1..E(WIDTH). FIX writes HI/LO on edge E(WIDTH+1).
- The new HI/LO is visible after edge WIDTH+1: 33 cycles at WIDTH=32.
- FREEZE rises after E0 and falls after the FIX edge. A dependent MFHI issued back-to-back therefore reads the new value.
- MTHI/MTLO: one-cycle write, no FREEZE.
- MFHI/MFLO: zero-cycle combinational read.

## Configuration
- MULDIV_SIGNED_EN defined: op 0/2 perform signed magnitude conversion and FIX-stage sign correction as above.
- MULDIV_SIGNED_EN undefined: op 0/2 behave exactly as 1/3 (unsigned). The sign latch and negation logic are omitted. FIX still takes one cycle, so latency is unchanged.

## Test plan
- Reset mid-RUN of MULTU -> HI=LO=0, FREEZE=0 immediately; state IDLE after release.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001; FREEZE high exactly 33 cycles.
- MULT -7 x 3 (signed build) -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; unsigned build gives HI=0x00000002, LO=0xFFFFFFEB.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5, div_zero single-cycle pulse at the FIX edge.
- MTHI 0x1234 then DIVU started, FLUSH at cycle 10 -> FREEZE low next cycle, HI=0x1234 and LO unchanged; MFHI returns 0x1234.
